// File: rtl/divider_8bits_pkg.sv
// Shared constants for the sequential restoring divider: state encoding and default width.
package div_pkg;
    localparam int unsigned DEFAULT_WIDTH = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_FIM  = 2'd2;
endpackage

// File: rtl/divider_8bits_if.sv
// start/DONE handshake bundle shared with the multiplier so the top level drives both alike.
interface divider_8bits_if
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             BUSY;
    logic             DIV0;
    logic             DONE;

    modport master (output start, X, Y, input  Q, R, BUSY, DIV0, DONE);
    modport slave  (input  start, X, Y, output Q, R, BUSY, DIV0, DONE);
endinterface

// File: rtl/divider_8bits_step.sv
// One restoring-division step: trial subtract of the divisor from the shifted-in partial remainder.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             msb,
    input  logic [WIDTH-1:0] dv,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    logic [WIDTH:0] trial;

    // rem < dv on entry, so the restored value always fits back into WIDTH bits
    always_comb begin
        trial    = {rem, msb} - {1'b0, dv};
        q_bit    = ~trial[WIDTH];
        rem_next = q_bit ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], msb};
    end
endmodule

// File: rtl/divider_8bits.sv
// Sequential restoring divider: X / Y -> Q, R, one quotient bit per clock, start/DONE handshake.
module divider_8bits
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           RESET,
    divider_8bits_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] sh, sh_n;
    logic [WIDTH-1:0] rem, rem_n;
    logic [WIDTH-1:0] dv, dv_n;
    logic [WIDTH-1:0] q, q_n;
    logic [WIDTH-1:0] r, r_n;
    logic             busy, busy_n;
    logic             div0, div0_n;
    logic             done, done_n;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .msb      (sh[WIDTH-1]),
        .dv       (dv),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state <= S_IDLE;
            cnt   <= '0;
            sh    <= '0;
            rem   <= '0;
            dv    <= '0;
            q     <= '0;
            r     <= '0;
            busy  <= 1'b0;
            div0  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sh    <= sh_n;
            rem   <= rem_n;
            dv    <= dv_n;
            q     <= q_n;
            r     <= r_n;
            busy  <= busy_n;
            div0  <= div0_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = sh;
        rem_n   = rem;
        dv_n    = dv;
        q_n     = q;
        r_n     = r;
        busy_n  = busy;
        div0_n  = div0;
        done_n  = done;

        case (state)
            S_IDLE, S_FIM: begin
                // start restarts from FIM too, giving back-to-back operation
                if (bus.start) begin
                    sh_n  = bus.X;
                    dv_n  = bus.Y;
                    rem_n = '0;
                    cnt_n = '0;
                    if (bus.Y != '0) begin
                        state_n = S_ITER;
                        busy_n  = 1'b1;
                        div0_n  = 1'b0;
                        done_n  = 1'b0;
                    end else begin
                        state_n = S_FIM;
                        q_n     = '1;
                        r_n     = bus.X;
                        busy_n  = 1'b0;
                        div0_n  = 1'b1;
                        done_n  = 1'b1;
                    end
                end
            end
            S_ITER: begin
                sh_n  = {sh[WIDTH-2:0], step_q};
                rem_n = step_rem;
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_n = S_FIM;
                    q_n     = {sh[WIDTH-2:0], step_q};
                    r_n     = step_rem;
                    busy_n  = 1'b0;
                    div0_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
                done_n  = 1'b0;
            end
        endcase
    end

    assign bus.Q    = q;
    assign bus.R    = r;
    assign bus.BUSY = busy;
    assign bus.DIV0 = div0;
    assign bus.DONE = done;
endmodule
